// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: issues one data-memory access per request over a
// req/ack handshake, formats load data, and stalls the pipeline until completion.
module lsu_mem_stage #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   // Request handshake: an op transfers on a rising edge where req_valid && req_ready.
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        resp_valid,
   output logic        resp_wb,
   output logic [4:0]  resp_rd,
   output logic [31:0] resp_data,
   output logic [1:0]  resp_err,
   output logic        stall,
   output logic [1:0]  dbg_state
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_ALIGN = 2'b01;
   localparam logic [1:0] ERR_TMO   = 2'b10;
   localparam logic [1:0] ERR_SIZE  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_RESP   = 2'b10
   } state_e;

   state_e         state_q, state_d;
   logic           we_q, we_d;
   logic [1:0]     size_q, size_d;
   logic           uns_q, uns_d;
   logic [31:0]    addr_q, addr_d;
   logic [4:0]     rd_q, rd_d;
   logic [3:0]     be_q, be_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    data_q, data_d;
   logic [1:0]     err_q, err_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic [31:0]    rshift;
   logic [31:0]    load_fmt;
   logic           misaligned;

   // Lane extraction uses the latched address so the result is independent of req_*.
   always_comb begin
      rshift   = dmem_rdata >> {addr_q[1:0], 3'b000};
      load_fmt = dmem_rdata;
      case (size_q)
         2'b00:   load_fmt = uns_q ? {24'h0, rshift[7:0]}  : {{24{rshift[7]}},  rshift[7:0]};
         2'b01:   load_fmt = uns_q ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
         default: load_fmt = dmem_rdata;
      endcase
   end

   always_comb begin
      misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               rd_d    = req_rd;
               data_d  = 32'h0;
               cnt_d   = '0;
               case (req_size)
                  2'b00: begin
                     be_d    = 4'b0001 << req_addr[1:0];
                     wdata_d = {4{req_wdata[7:0]}};
                  end
                  2'b01: begin
                     be_d    = 4'b0011 << req_addr[1:0];
                     wdata_d = {2{req_wdata[15:0]}};
                  end
                  default: begin
                     be_d    = 4'b1111;
                     wdata_d = req_wdata;
                  end
               endcase
               if (req_size == 2'b11) begin
                  err_d   = ERR_SIZE;
                  state_d = S_RESP;
               end else if (misaligned) begin
                  err_d   = ERR_ALIGN;
                  state_d = S_RESP;
               end else begin
                  err_d   = ERR_OK;
                  state_d = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            // Ack is tested first so it wins over a timeout in the same cycle.
            if (dmem_ack) begin
               data_d  = load_fmt;
               err_d   = ERR_OK;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = ERR_TMO;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= 32'h0;
         rd_q    <= 5'd0;
         be_q    <= 4'h0;
         wdata_q <= 32'h0;
         data_q  <= 32'h0;
         err_q   <= 2'b00;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Every output is a decode of state or a registered field.
   always_comb begin
      req_ready  = (state_q == S_IDLE);
      stall      = (state_q != S_IDLE);
      dmem_req   = (state_q == S_ACCESS);
      dmem_we    = we_q;
      dmem_addr  = {addr_q[31:2], 2'b00};
      dmem_be    = be_q;
      dmem_wdata = wdata_q;
      resp_valid = (state_q == S_RESP);
      resp_wb    = (state_q == S_RESP) && !we_q && (err_q == ERR_OK) && (rd_q != 5'd0);
      resp_rd    = (state_q == S_RESP) ? rd_q : 5'd0;
      resp_err   = (state_q == S_RESP) ? err_q : 2'b00;
      resp_data  = resp_wb ? data_q : 32'h0;
      dbg_state  = state_q;
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed cases followed by random ops, each checked
// against an arithmetic model of addressing, lane steering, load extension and timing.
module tb_lsu_mem_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [4:0]  req_rd = 5'd0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'h0;
   logic        resp_valid;
   logic        resp_wb;
   logic [4:0]  resp_rd;
   logic [31:0] resp_data;
   logic [1:0]  resp_err;
   logic        stall;
   logic [1:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   lsu_mem_stage #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata),
      .resp_valid(resp_valid), .resp_wb(resp_wb), .resp_rd(resp_rd),
      .resp_data(resp_data), .resp_err(resp_err), .stall(stall),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] size);
      return 1 << size;
   endfunction

   function automatic logic [1:0] m_err(input logic [1:0] size, input logic [31:0] addr);
      if (size == 2'b11) return 2'b11;
      if ((addr % nbytes(size)) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
      int nb = nbytes(size);
      return 4'(((1 << nb) - 1) << (addr % 4));
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
      longint lw = longint'(w);
      if (size == 2'b00) return 32'((lw % 256) * 32'h0101_0101);
      if (size == 2'b01) return 32'((lw % 65536) * 32'h0001_0001);
      return w;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                          input logic [31:0] addr, input logic [31:0] rdata);
      int     nb   = nbytes(size);
      longint span = longint'(1) << (8 * nb);
      longint v    = (longint'(rdata) >> (8 * (addr % 4))) % span;
      if (!uns && nb < 4 && v >= span / 2) v = v - span;
      return 32'(v);
   endfunction

   // ---------------- driver + checker for one op ----------------
   task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int ack_delay, input logic [31:0] rdata);
      logic [1:0] e_err;
      logic       e_wb;
      int         e_lat, e_reqs, k, reqs;
      logic       got;
      e_err  = m_err(size, addr);
      e_wb   = !we && (e_err == 2'b00) && (rd != 5'd0);
      if (e_err != 2'b00) begin
         e_lat  = 0;
         e_reqs = 0;
      end else if (ack_delay < TO) begin
         e_lat  = ack_delay + 1;
         e_reqs = ack_delay + 1;
      end else begin
         e_lat  = TO;
         e_reqs = TO;
         e_err  = 2'b10;
         e_wb   = 1'b0;
      end
      @(negedge clk);
      req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
      check("req_ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wdata = $urandom;
      k = 0; reqs = 0; got = 1'b0;
      while (!got && k < 12) begin
         if (resp_valid) begin
            got = 1'b1;
         end else begin
            if (dmem_req) begin
               check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
               check("dmem_be", 32'(dmem_be), 32'(m_be(size, addr)));
               if (reqs == 0) begin
                  check("dmem_we", 32'(dmem_we), 32'(we));
                  if (we) check("dmem_wdata", dmem_wdata, m_wdata(size, wdata));
               end
               dmem_ack   = (reqs == ack_delay);
               dmem_rdata = dmem_ack ? rdata : $urandom;
               reqs++;
            end
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            k++;
         end
      end
      check("resp_seen", 32'(got), 32'd1);
      if (got) begin
         check("resp_latency", 32'(k), 32'(e_lat));
         check("dmem_req_cycles", 32'(reqs), 32'(e_reqs));
         check("resp_err", 32'(resp_err), 32'(e_err));
         check("resp_wb", 32'(resp_wb), 32'(e_wb));
         check("resp_rd", 32'(resp_rd), 32'(rd));
         check("resp_data", resp_data, e_wb ? m_load(size, uns, addr, rdata) : 32'h0);
         check("stall_resp", 32'(stall), 32'd1);
      end
      @(posedge clk); #1;
      check("resp_one_cycle", 32'(resp_valid), 32'd0);
      check("ready_after", 32'(req_ready), 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_dmem_be", 32'(dmem_be), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 5'd5, 0, 32'hDEAD_BEEF);   // LW
      do_op(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd7, 1, 32'h80FF_0000);   // LB
      do_op(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 5'd7, 2, 32'h80FF_0000);   // LBU
      do_op(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 5'd9, 0, 32'h0);   // SH
      do_op(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd3, 0, 32'h0);          // misaligned
      do_op(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 5'd3, 0, 32'h0);          // illegal size
      do_op(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 5'd4, 99, 32'h0);         // timeout
      do_op(1'b0, 2'b10, 1'b0, 32'h0000_0404, 32'h0, 5'd4, TO - 1, 32'h1357_9BDF);
      do_op(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 5'd0, 0, 32'h8001_7FFF);   // rd=0
      do_op(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, 5'd6, 0, 32'h8001_7FFF);   // LH upper

      // Reset in the middle of an access.
      @(negedge clk);
      req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_0800; req_rd = 5'd2;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("mid_dmem_req", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_mid_dmem_req", 32'(dmem_req), 32'd0);
      check("rst_mid_stall", 32'(stall), 32'd0);
      check("rst_mid_resp", 32'(resp_valid), 32'd0);
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      check("late_ack_resp", 32'(resp_valid), 32'd0);
      check("late_ack_req", 32'(dmem_req), 32'd0);
      do_op(1'b0, 2'b10, 1'b0, 32'h0000_0800, 32'h0, 5'd2, 1, 32'hCAFE_F00D);

      // Random ops.
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  sz;
         logic [31:0] a;
         sz = 2'($urandom_range(0, 3));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~(32'(nbytes(sz)) - 32'd1);
         do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
               5'($urandom_range(0, 31)), $urandom_range(0, 5), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
